// File: rtl/seg_scan_reader.sv
// Sweeps the display select 0..15, decodes the active-low segment bus
// back to a nibble and keeps a 16-entry capture buffer with error flags.
module seg_scan_reader #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [3:0] sel_o,
  input  logic [6:0] hex_i,
  input  logic [3:0] rd_addr,
  output logic [3:0] rd_data,
  output logic       rd_err,
  output logic [4:0] err_count,
  output logic       err_any
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [3:0] WLAST = 4'(SETTLE - 1);

  state_t     state, state_n;
  logic [3:0] wcnt;
  logic [3:0] nib_q [16];
  logic       err_q [16];
  logic [3:0] dec_nib;
  logic       dec_bad;

  always_comb begin
    dec_nib = 4'h0;
    dec_bad = 1'b0;
    case (hex_i)
      7'h40: dec_nib = 4'h0;
      7'h79: dec_nib = 4'h1;
      7'h24: dec_nib = 4'h2;
      7'h30: dec_nib = 4'h3;
      7'h19: dec_nib = 4'h4;
      7'h12: dec_nib = 4'h5;
      7'h02: dec_nib = 4'h6;
      7'h78: dec_nib = 4'h7;
      7'h00: dec_nib = 4'h8;
      7'h10: dec_nib = 4'h9;
      7'h08: dec_nib = 4'hA;
      7'h03: dec_nib = 4'hB;
      7'h46: dec_nib = 4'hC;
      7'h21: dec_nib = 4'hD;
      7'h06: dec_nib = 4'hE;
      7'h0E: dec_nib = 4'hF;
      default: dec_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_n = S_SETTLE;
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (wcnt == WLAST) state_n = S_SAMPLE;
      end
      S_SAMPLE: begin
        busy = 1'b1;
        if (sel_o == 4'hF) state_n = S_DONE;
        else               state_n = S_SETTLE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_o     <= 4'h0;
      wcnt      <= 4'h0;
      err_count <= 5'd0;
      for (int i = 0; i < 16; i++) begin
        nib_q[i] <= 4'h0;
        err_q[i] <= 1'b0;
      end
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            sel_o     <= 4'h0;
            wcnt      <= 4'h0;
            err_count <= 5'd0;
          end
        end
        S_SETTLE: wcnt <= wcnt + 4'h1;
        S_SAMPLE: begin
          nib_q[sel_o] <= dec_nib;
          err_q[sel_o] <= dec_bad;
          if (dec_bad && err_count != 5'd16)
            err_count <= err_count + 5'd1;
          if (sel_o != 4'hF) sel_o <= sel_o + 4'h1;
          wcnt <= 4'h0;
        end
        S_DONE: ;
      endcase
    end
  end

  assign rd_data = nib_q[rd_addr];
  assign rd_err  = err_q[rd_addr];
  assign err_any = (err_count != 5'd0);

endmodule

// File: tb/tb_seg_scan_reader.sv
// Directed bench for seg_scan_reader: a driver model feeds the segment
// bus from sel_o, with optional illegal codes at indices 5 and 12.
module tb_seg_scan_reader;

  logic       clk = 1'b0;
  logic       rst, start, start1;
  logic       busy, done, busy1, done1;
  logic [3:0] sel_o, sel1;
  logic [6:0] hex_i, hex1;
  logic [3:0] rd_addr, rd_data, rd_data1;
  logic       rd_err, rd_err1;
  logic [4:0] err_count, err_count1;
  logic       err_any, err_any1;
  logic       inj;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  seg_scan_reader #(.SETTLE(2)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .sel_o(sel_o), .hex_i(hex_i), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_err(rd_err),
    .err_count(err_count), .err_any(err_any)
  );

  seg_scan_reader #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .sel_o(sel1), .hex_i(hex1), .rd_addr(rd_addr),
    .rd_data(rd_data1), .rd_err(rd_err1),
    .err_count(err_count1), .err_any(err_any1)
  );

  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'h0: seg = 7'h40; 4'h1: seg = 7'h79;
      4'h2: seg = 7'h24; 4'h3: seg = 7'h30;
      4'h4: seg = 7'h19; 4'h5: seg = 7'h12;
      4'h6: seg = 7'h02; 4'h7: seg = 7'h78;
      4'h8: seg = 7'h00; 4'h9: seg = 7'h10;
      4'hA: seg = 7'h08; 4'hB: seg = 7'h03;
      4'hC: seg = 7'h46; 4'hD: seg = 7'h21;
      4'hE: seg = 7'h06; default: seg = 7'h0E;
    endcase
  endfunction

  always_comb begin
    hex_i = seg(sel_o);
    if (inj && sel_o == 4'd5)  hex_i = 7'h7F;
    if (inj && sel_o == 4'd12) hex_i = 7'h55;
    hex1 = seg(sel1);
  end

  // Cycle c=1 is the first cycle after the accepting edge.
  task automatic run_scan(input bit mid, output int nbusy,
                          output int tdone, output int ndone,
                          output int seqbad, output logic [4:0] ec1);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    nbusy = 0; tdone = -1; ndone = 0; seqbad = 0; ec1 = 5'h1F;
    for (int c = 1; c <= 56; c++) begin
      if (c == 1) ec1 = err_count;
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (tdone < 0) tdone = c;
      end
      if (c <= 48 && sel_o !== 4'((c - 1) / 3)) seqbad++;
      if (c > 48 && sel_o !== 4'hF) seqbad++;
      start = (mid && c == 10);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; start1 = 1'b0; inj = 1'b0; rd_addr = 4'h0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sel_o !== 4'h0 ||
        err_count !== 5'd0 || err_any !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs busy=%b done=%b sel=%h ec=%0d any=%b want 0",
               busy, done, sel_o, err_count, err_any);
    end
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i); #1;
      checks++;
      if (rd_data !== 4'h0 || rd_err !== 1'b0) begin
        errors++;
        $display("FAIL reset_buf[%0d] got %h/%b want 0/0", i, rd_data, rd_err);
      end
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_legal_scan;
    int nb, td, nd, sb;
    logic [4:0] ec1;
    inj = 1'b0;
    run_scan(1'b0, nb, td, nd, sb, ec1);
    checks++;
    if (nb != 48 || td != 49 || nd != 1 || sb != 0) begin
      errors++;
      $display("FAIL legal_timing busy=%0d done_at=%0d dones=%0d seqbad=%0d want 48/49/1/0",
               nb, td, nd, sb);
    end
    checks++;
    if (err_count !== 5'd0 || err_any !== 1'b0) begin
      errors++;
      $display("FAIL legal_errcnt got %0d/%b want 0/0", err_count, err_any);
    end
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i); #1;
      checks++;
      if (rd_data !== 4'(i) || rd_err !== 1'b0) begin
        errors++;
        $display("FAIL legal_buf[%0d] got %h/%b want %h/0", i, rd_data, rd_err, i);
      end
    end
  endtask

  task automatic test_illegal;
    int nb, td, nd, sb;
    logic [4:0] ec1;
    logic [3:0] ed;
    logic       ee;
    inj = 1'b1;
    run_scan(1'b0, nb, td, nd, sb, ec1);
    inj = 1'b0;
    checks++;
    if (err_count !== 5'd2 || err_any !== 1'b1 || td != 49) begin
      errors++;
      $display("FAIL illegal_errcnt got %0d/%b done_at=%0d want 2/1/49",
               err_count, err_any, td);
    end
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i); #1;
      ee = (i == 5 || i == 12);
      ed = ee ? 4'h0 : 4'(i);
      checks++;
      if (rd_data !== ed || rd_err !== ee) begin
        errors++;
        $display("FAIL illegal_buf[%0d] got %h/%b want %h/%b",
                 i, rd_data, rd_err, ed, ee);
      end
    end
  endtask

  task automatic test_start_busy;
    int nb, td, nd, sb;
    logic [4:0] ec1;
    run_scan(1'b1, nb, td, nd, sb, ec1);
    checks++;
    if (nd != 1 || td != 49 || sb != 0 || nb != 48) begin
      errors++;
      $display("FAIL start_busy dones=%0d done_at=%0d seqbad=%0d busy=%0d want 1/49/0/48",
               nd, td, sb, nb);
    end
    checks++;
    if (ec1 !== 5'd0 || err_count !== 5'd0) begin
      errors++;
      $display("FAIL start_busy_errcnt first=%0d end=%0d want 0/0", ec1, err_count);
    end
  endtask

  task automatic test_reset_mid;
    int nb, td, nd, sb, n;
    logic [4:0] ec1;
    bit hit;
    inj = 1'b1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      if (sel_o == 4'd7) hit = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!hit || err_count !== 5'd1) begin
      errors++;
      $display("FAIL rst_mid_reach hit=%b ec=%0d want 1/1", hit, err_count);
    end
    rst = 1'b1; #1;
    checks++;
    if (busy !== 1'b0 || sel_o !== 4'h0 || done !== 1'b0 ||
        err_count !== 5'd0 || err_any !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_outputs busy=%b sel=%h done=%b ec=%0d any=%b want 0",
               busy, sel_o, done, err_count, err_any);
    end
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i); #1;
      checks++;
      if (rd_data !== 4'h0 || rd_err !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_buf[%0d] got %h/%b want 0/0", i, rd_data, rd_err);
      end
    end
    inj = 1'b0;
    @(negedge clk) rst = 1'b0;
    n = 0;
    for (int c = 0; c < 60; c++) begin
      if (done || busy) n++;
      @(negedge clk);
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL rst_mid_quiet active_cycles=%0d want 0", n);
    end
    run_scan(1'b0, nb, td, nd, sb, ec1);
    checks++;
    if (nb != 48 || td != 49 || nd != 1 || sb != 0 || err_count !== 5'd0) begin
      errors++;
      $display("FAIL rst_mid_rescan busy=%0d done_at=%0d dones=%0d seqbad=%0d ec=%0d",
               nb, td, nd, sb, err_count);
    end
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i); #1;
      checks++;
      if (rd_data !== 4'(i) || rd_err !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_rescan_buf[%0d] got %h/%b want %h/0",
                 i, rd_data, rd_err, i);
      end
    end
  endtask

  task automatic test_settle1;
    int nb, td, sb;
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    nb = 0; td = -1; sb = 0;
    for (int c = 1; c <= 40; c++) begin
      if (busy1) nb++;
      if (done1 && td < 0) td = c;
      if (c <= 32 && sel1 !== 4'((c - 1) / 2)) sb++;
      @(negedge clk);
    end
    checks++;
    if (nb != 32 || td != 33 || sb != 0) begin
      errors++;
      $display("FAIL settle1_timing busy=%0d done_at=%0d seqbad=%0d want 32/33/0",
               nb, td, sb);
    end
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i); #1;
      checks++;
      if (rd_data1 !== 4'(i) || rd_err1 !== 1'b0) begin
        errors++;
        $display("FAIL settle1_buf[%0d] got %h/%b want %h/0",
                 i, rd_data1, rd_err1, i);
      end
    end
  endtask

  task automatic test_back_to_back;
    int d1, d2;
    inj = 1'b1;
    rd_addr = 4'd5;
    d1 = -1; d2 = -1;
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 110; c++) begin
      if (done) begin
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
      if (c == 49 || c == 50 || c == 51 || c == 60 || c == 70 || c == 99)
        checks++;
      if (c == 49 && (err_count !== 5'd2 || done !== 1'b1)) begin
        errors++;
        $display("FAIL b2b_first_done ec=%0d done=%b want 2/1", err_count, done);
      end
      if (c == 50 && (busy !== 1'b0 || done !== 1'b0)) begin
        errors++;
        $display("FAIL b2b_idle_gap busy=%b done=%b want 0/0", busy, done);
      end
      if (c == 51 && (busy !== 1'b1 || err_count !== 5'd0)) begin
        errors++;
        $display("FAIL b2b_second_start busy=%b ec=%0d want 1/0", busy, err_count);
      end
      if (c == 60 && (rd_err !== 1'b1 || rd_data !== 4'h0)) begin
        errors++;
        $display("FAIL b2b_old_entry5 got %h/%b want 0/1", rd_data, rd_err);
      end
      if (c == 70 && (rd_err !== 1'b0 || rd_data !== 4'h5)) begin
        errors++;
        $display("FAIL b2b_new_entry5 got %h/%b want 5/0", rd_data, rd_err);
      end
      if (c == 99 && (done !== 1'b1 || err_count !== 5'd0 || err_any !== 1'b0)) begin
        errors++;
        $display("FAIL b2b_second_done done=%b ec=%0d any=%b want 1/0/0",
                 done, err_count, err_any);
      end
      if (c == 49) inj = 1'b0;
      if (c == 52) start = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (d1 != 49 || d2 != 99) begin
      errors++;
      $display("FAIL b2b_done_times got %0d/%0d want 49/99", d1, d2);
    end
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i); #1;
      checks++;
      if (rd_data !== 4'(i) || rd_err !== 1'b0) begin
        errors++;
        $display("FAIL b2b_buf[%0d] got %h/%b want %h/0", i, rd_data, rd_err, i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_legal_scan();
    test_illegal();
    test_start_busy();
    test_reset_mid();
    test_settle1();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_reader.md
Name: seg_scan_reader

Overview:
- Reverse-direction companion to the 16-way nibble-select / 7-segment hex display driver.
- Drives the 4-bit select into the driver and sweeps it through indices 0..15.
- At each index, samples the active-low segment bus the driver produces, decodes it back to a nibble, and stores it in a 16x4 capture buffer with a per-entry illegal-pattern flag.
- Used for self-test and readback of the display datapath.

Parameters:
- SETTLE, 2: cycles sel_o is held stable before the sampling cycle; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  scan request; accepted only in IDLE.
- busy  output  1  high while a scan is in progress (SETTLE and SAMPLE states).
- done  output  1  one-cycle pulse when the scan completes.
- sel_o  output  4  select driven to the display driver's S input.
- hex_i  input  7  active-low segment bus from the driver; bit0 = segment a … bit6 = segment g.
- rd_addr  input  4  capture buffer read index.
- rd_data  output  4  decoded nibble stored at rd_addr (combinational read).
- rd_err  output  1  illegal-pattern flag stored at rd_addr (combinational read).
- err_count  output  5  number of illegal patterns seen in the last or current scan (0..16).
- err_any  output  1  high when err_count != 0.

Behaviour:
- Clock, reset and reset values:
  - Single clock domain (clk); rst is asynchronous, active-high.
  - On rst: state=IDLE, busy=0, done=0, sel_o=0, err_count=0, err_any=0.
  - On rst: all 16 buffer nibbles=0 and all error flags=0.
  - Reset asserted mid-scan aborts the scan immediately; no done pulse is generated.
- Decode table: hex_i (hex value of bits [6:0]) -> nibble.
  - 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7.
  - 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F.
  - Any other code is illegal: the stored nibble is 0, the error flag is 1, and err_count increments.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 -> SETTLE; sel_o<=0; wait counter<=0; err_count<=0.
  - Buffer entries are not cleared at scan start; each is overwritten when its index is sampled.
- SETTLE:
  - Occupies exactly SETTLE cycles with sel_o stable, then moves to SAMPLE.
- SAMPLE (one cycle):
  - At the closing edge, hex_i is decoded and written to buf[sel_o] and err[sel_o].
  - err_count increments if the code is illegal; it saturates at 16, which is unreachable by construction.
  - If sel_o==15 -> DONE.
  - Otherwise sel_o<=sel_o+1, wait counter<=0, and the FSM returns to SETTLE.
- DONE (one cycle):
  - done=1, busy=0, then IDLE.
  - sel_o stays at 15 until the next start.
- Latency:
  - busy is high for 16*(SETTLE+1) cycles, starting the cycle after start is sampled.
  - done is asserted in the following cycle.
  - SETTLE=2: 48 busy cycles, done on the 49th cycle after the accepting edge.
- start while busy or in DONE is ignored; the current scan is not restarted.
- start held high continuously: a new scan begins in the cycle after IDLE is re-entered, i.e. one idle cycle between scans.
- Read port:
  - Purely combinational from buffer state; valid at any time.
  - During a scan it shows already-written new values and old values elsewhere.
- hex_i is sampled only in SAMPLE; glitches during SETTLE have no effect.
- err_any is a combinational function of err_count.

Test Plan:
- Legal scan: model driver with a_i = i (i=0..15), start=1 for one cycle.
  - Required: rd_data[i]=i and rd_err=0 for all i.
  - Required: err_count=0; done exactly 49 cycles after the start edge with SETTLE=2.
- Illegal injection: force hex_i=7F when sel_o=5 and hex_i=55 when sel_o=12.
  - Required: rd_data[5]=0, rd_err[5]=1, rd_data[12]=0, rd_err[12]=1.
  - Required: err_count=2, err_any=1; all other entries correct.
- Start while busy: pulse start again at cycle 10 of a scan.
  - Required: no restart; sel_o continues its sequence; exactly one done pulse.
- Reset mid-scan: assert rst while sel_o=7.
  - Required: busy=0, sel_o=0, done never pulses; all rd_data=0, rd_err=0, err_count=0.
  - Required: a new start completes a full scan normally.
- Parameter check, SETTLE=1: full scan takes 32 busy cycles.
  - Required: each sel_o value is held exactly 2 cycles.
- Back-to-back scans:
  - First scan with one illegal code, then a clean second scan.
  - Required: err_count reads 0 on the first busy cycle of the second scan and 0 at its done.
  - Required: error flags are cleared as entries are rewritten.
